tcb_lib_register_response: RTL and testbench
============================================

Name: tcb_lib_register_response

Overview:
- Register slice for the TCB response path; complement of the request-path register slice.
- Request signals pass through combinationally.
- Response data/error from the subordinate side are registered once, so the manager sees response delay DLY+1.
- Inserted between an interconnect and a slow-timing subordinate to break the read-data return path.

Parameters:
AW, 32, address width
DW, 32, data width
BW, DW/8, byte-enable width
DLY, 1, response delay of the downstream subordinate in cycles (>=0); upstream delay becomes DLY+1
GRN, 1, bus-hold granularity in bytes; rdt lanes updated in groups of GRN bytes (BW % GRN == 0)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
sub_vld  in  1  request valid from manager device
sub_rdy  out  1  request ready to manager device
sub_wen  in  1  write enable
sub_adr  in  AW  address
sub_ben  in  BW  byte enables
sub_wdt  in  DW  write data
sub_rdt  out  DW  registered read data
sub_err  out  1  registered error
man_vld  out  1  request valid to subordinate device
man_rdy  in  1  request ready from subordinate device
man_wen  out  1  write enable
man_adr  out  AW  address
man_ben  out  BW  byte enables
man_wdt  out  DW  write data
man_rdt  in  DW  read data, valid DLY cycles after handshake
man_err  in  1  error, valid DLY cycles after handshake

Behaviour:
- Request path fully combinational:
  - man_vld=sub_vld, man_wen/adr/ben/wdt = sub_*.
  - sub_rdy=man_rdy.
  - No added request latency.
- Transfer: trn = man_vld & man_rdy.
- Tracking delay line, depth DLY, per entry {act, wen, ben[BW-1:0]}:
  - Stage 0 captures {trn, man_wen, man_ben} every cycle.
  - Each later stage shifts every cycle; no stall (TCB response has no backpressure).
  - Output tap tap_* is the entry DLY cycles old.
  - DLY=0: tap is the current-cycle combinational {trn, man_wen, man_ben}; no storage.
- Response register, updated on clk rising edge:
  - If tap_act: sub_err <= man_err.
  - If tap_act & ~tap_wen, for each GRN-byte group g: if any tap_ben bit in g is set, sub_rdt[g] <= man_rdt[g]. Otherwise group g holds.
  - Writes (tap_wen=1) update sub_err only; sub_rdt holds.
  - If tap_act=0: sub_rdt and sub_err hold (bus hold, power saving).
- Latency: sub_rdt/sub_err valid exactly DLY+1 cycles after the sub_vld&sub_rdy handshake.
- Back-to-back transfers: one response per cycle, no bubbles, order preserved.
- Reset (rst_n=0, asynchronous): all tracking act bits=0, sub_rdt=0, sub_err=0.
- Reset mid-operation: in-flight responses are discarded. After release, outputs hold 0 until the first new response.
- Request stall (man_rdy=0): no entry enters the tracker; earlier entries keep shifting and complete normally.

Decomposition:
- tcb_pkg: typedef tcb_trk_t {act, wen, ben}; parameterized by BW via a parameterized struct or a localparam width function.
- tcb_pkg: helper localparam for group count BW/GRN.
- One sub-module: tcb_lib_delay_line, a parameterized-width/depth shift register with async active-low reset and a DLY=0 bypass, reused by future response-path blocks.

Test Plan:
- DLY=1, read adr=0x10 ben=4'hF, man_rdt=0xDEADBEEF one cycle after the handshake -> sub_rdt=0xDEADBEEF two cycles after the handshake, sub_err=0.
- DLY=1, back-to-back reads returning 0x11111111, 0x22222222, 0x33333333 -> sub_rdt shows the same values on consecutive cycles 2, 3, 4 after the first handshake.
- Read ben=4'b0100 with man_rdt=0xAABBCCDD, prior sub_rdt=0x01234567 -> sub_rdt=0x01BB4567. With GRN=2 -> 0xAABB4567.
- Write wen=1 with man_err=1, prior sub_rdt=0x5A5A5A5A -> sub_err=1, sub_rdt stays 0x5A5A5A5A.
- DLY=2, read issued, rst_n pulsed low one cycle later -> sub_rdt=0 and sub_err=0 immediately; no update follows after release.
- DLY=0, man_rdy=0 for 3 cycles then 1, read returning 0x0000CAFE -> sub_rdy tracks man_rdy combinationally; sub_rdt=0x0000CAFE one cycle after the accepted handshake only.

Source files
------------

// File: rtl/tcb_pkg.sv
// Shared sizing helpers for the TCB library response-path blocks.
// The tracking entry layout is {act, wen, ben[BW-1:0]}; blocks build the struct locally from BW.
package tcb_pkg;

  // Width of one tracking entry {act, wen, ben}.
  function automatic int unsigned trk_width(input int unsigned bw);
    return bw + 2;
  endfunction

  // Number of GRN-byte lane groups in a BW-byte bus.
  function automatic int unsigned grp_count(input int unsigned bw, input int unsigned grn);
    return bw / grn;
  endfunction

endpackage

// File: rtl/tcb_lib_delay_line.sv
// Fixed-depth shift register with async active-low reset; DLY=0 is a straight wire.
// Never stalls: every stage advances every cycle.
module tcb_lib_delay_line #(
  parameter int unsigned W   = 1,
  parameter int unsigned DLY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DLY == 0) begin : g_bypass
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign dout = din;
    end else begin : g_pipe
      logic [W-1:0] stg [DLY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DLY; i++) stg[i] <= '0;
        end else begin
          stg[0] <= din;
          for (int i = 1; i < DLY; i++) stg[i] <= stg[i-1];
        end
      end

      assign dout = stg[DLY-1];
    end
  endgenerate

endmodule

// File: rtl/tcb_lib_register_response.sv
// TCB register slice on the response path: request passes through, rdt/err are registered once.
// Upstream response delay becomes DLY+1; idle cycles and unselected lane groups hold their value.
module tcb_lib_register_response
  import tcb_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned BW  = DW/8,
  parameter int unsigned DLY = 1,
  parameter int unsigned GRN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sub_vld,
  output logic          sub_rdy,
  input  logic          sub_wen,
  input  logic [AW-1:0] sub_adr,
  input  logic [BW-1:0] sub_ben,
  input  logic [DW-1:0] sub_wdt,
  output logic [DW-1:0] sub_rdt,
  output logic          sub_err,
  output logic          man_vld,
  input  logic          man_rdy,
  output logic          man_wen,
  output logic [AW-1:0] man_adr,
  output logic [BW-1:0] man_ben,
  output logic [DW-1:0] man_wdt,
  input  logic [DW-1:0] man_rdt,
  input  logic          man_err
);

  localparam int unsigned GRP_NUM = grp_count(BW, GRN);
  localparam int unsigned GRP_W   = 8 * GRN;

  typedef struct packed {
    logic          act;
    logic          wen;
    logic [BW-1:0] ben;
  } tcb_trk_t;

  tcb_trk_t           trk_in;
  tcb_trk_t           tap;
  logic               trn;
  logic [GRP_NUM-1:0] grp_upd;

  assign man_vld = sub_vld;
  assign man_wen = sub_wen;
  assign man_adr = sub_adr;
  assign man_ben = sub_ben;
  assign man_wdt = sub_wdt;
  assign sub_rdy = man_rdy;

  assign trn    = man_vld & man_rdy;
  assign trk_in = '{act: trn, wen: man_wen, ben: man_ben};

  // Remembers which cycles carry a response and which byte lanes it owns.
  tcb_lib_delay_line #(
    .W   (trk_width(BW)),
    .DLY (DLY)
  ) u_trk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (trk_in),
    .dout  (tap)
  );

  always_comb begin
    grp_upd = '0;
    for (int g = 0; g < GRP_NUM; g++) begin
      grp_upd[g] = tap.act & ~tap.wen & (|tap.ben[g*GRN +: GRN]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_rdt <= '0;
      sub_err <= 1'b0;
    end else begin
      if (tap.act) sub_err <= man_err;
      for (int g = 0; g < GRP_NUM; g++) begin
        if (grp_upd[g]) sub_rdt[g*GRP_W +: GRP_W] <= man_rdt[g*GRP_W +: GRP_W];
      end
    end
  end

endmodule

// File: tb/tb_tcb_lib_register_response.sv
// Bench for tcb_lib_register_response: four instances (DLY/GRN = 1/1, 1/2, 2/1, 0/1) on shared inputs.
module tb_tcb_lib_register_response;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sub_vld, sub_wen, man_rdy, man_err;
  logic [31:0] sub_adr, sub_wdt, man_rdt;
  logic [3:0]  sub_ben;

  logic        rdy_o  [4];
  logic        err_o  [4];
  logic [31:0] rdt_o  [4];
  logic        mvld_o [4];
  logic        mwen_o [4];
  logic [31:0] madr_o [4];
  logic [3:0]  mben_o [4];
  logic [31:0] mwdt_o [4];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      tcb_lib_register_response #(
        .AW  (32),
        .DW  (32),
        .BW  (4),
        .DLY ((gi == 2) ? 2 : ((gi == 3) ? 0 : 1)),
        .GRN ((gi == 1) ? 2 : 1)
      ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sub_vld (sub_vld),
        .sub_rdy (rdy_o[gi]),
        .sub_wen (sub_wen),
        .sub_adr (sub_adr),
        .sub_ben (sub_ben),
        .sub_wdt (sub_wdt),
        .sub_rdt (rdt_o[gi]),
        .sub_err (err_o[gi]),
        .man_vld (mvld_o[gi]),
        .man_rdy (man_rdy),
        .man_wen (mwen_o[gi]),
        .man_adr (madr_o[gi]),
        .man_ben (mben_o[gi]),
        .man_wdt (mwdt_o[gi]),
        .man_rdt (man_rdt),
        .man_err (man_err)
      );
    end
  endgenerate

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    int          inst;
    logic [31:0] rdt;
    logic        err;
  } sb_t;

  sb_t sb[$];

  task automatic push(input int due, input int inst, input logic [31:0] rdt, input logic err);
    sb_t e;
    e.due = due; e.inst = inst; e.rdt = rdt; e.err = err;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL late_entry: inst %0d due %0d checked %0d", e.inst, e.due, cyc);
      end else begin
        chk($sformatf("rsp%0d.rdt", e.inst), rdt_o[e.inst], e.rdt);
        chk($sformatf("rsp%0d.err", e.inst), {31'd0, err_o[e.inst]}, {31'd0, e.err});
      end
    end
  end

  typedef struct {
    logic        vld;
    logic        wen;
    logic [3:0]  ben;
    logic [31:0] rdt;
    logic        err;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_err;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {vld, wen, ben, man_rdt, man_err, exp GRN=1, exp GRN=2, exp err}
    tbl[0]  = '{1'b1, 1'b0, 4'hF, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'hF, 32'h11111111, 1'b0, 32'h11111111, 32'h11111111, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 4'hF, 32'h22222222, 1'b0, 32'h22222222, 32'h22222222, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 4'hF, 32'h33333333, 1'b0, 32'h33333333, 32'h33333333, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 4'hF, 32'h01234567, 1'b0, 32'h01234567, 32'h01234567, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 4'h4, 32'hAABBCCDD, 1'b0, 32'h01BB4567, 32'hAABB4567, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'hF, 32'h5A5A5A5A, 1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 4'h1, 32'h12345678, 1'b1, 32'h5A5A5A78, 32'h5A5A5678, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 4'h0, 32'h00000000, 1'b0, 32'h5A5A5A78, 32'h5A5A5678, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'h8, 32'h9ABCDEF0, 1'b0, 32'h9A5A5A78, 32'h9ABC5678, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h9A5A5A78, 32'h9ABC5678, 1'b0};

    rst_n   = 1'b0;
    sub_vld = 1'b0; sub_wen = 1'b0; sub_adr = '0; sub_ben = '0; sub_wdt = '0;
    man_rdy = 1'b1; man_rdt = '0;   man_err = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset%0d.rdt", i), rdt_o[i], 32'h0);
      chk($sformatf("reset%0d.err", i), {31'd0, err_o[i]}, 32'h0);
    end
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Back-to-back table on DLY=1 instances: request k and response data k-1 share a cycle.
    for (int k = 0; k <= NV; k++) begin
      @(posedge clk); #1;
      if (k < NV) begin
        sub_vld = tbl[k].vld;
        sub_wen = tbl[k].wen;
        sub_ben = tbl[k].ben;
        sub_adr = 32'h10 + 32'(k * 4);
        sub_wdt = $urandom;
      end else begin
        sub_vld = 1'b0;
      end
      if (k > 0) begin
        man_rdt = tbl[k-1].rdt;
        man_err = tbl[k-1].err;
      end else begin
        man_rdt = 32'hFFFFFFFF;
        man_err = 1'b1;
      end
      if (k < NV) begin
        push(cyc + 2, 0, tbl[k].exp_a, tbl[k].exp_err);
        push(cyc + 2, 1, tbl[k].exp_b, tbl[k].exp_err);
        #1;
        chk("pass.adr", madr_o[0], sub_adr);
        chk("pass.wdt", mwdt_o[0], sub_wdt);
        chk("pass.ctl", {29'd0, mvld_o[0], mwen_o[0], rdy_o[0]}, {29'd0, sub_vld, sub_wen, man_rdy});
        chk("pass.ben", {28'd0, mben_o[1]}, {28'd0, sub_ben});
      end
    end
    @(posedge clk); #1;
    man_rdt = 32'hFFFFFFFF; man_err = 1'b1;
    repeat (3) @(posedge clk);

    // DLY=2 read completes three cycles after the request is driven.
    #1;
    sub_vld = 1'b1; sub_wen = 1'b0; sub_ben = 4'hF; sub_adr = 32'h40;
    push(cyc + 3, 2, 32'h0BADF00D, 1'b1);
    @(posedge clk); #1; sub_vld = 1'b0;
    @(posedge clk); #1; man_rdt = 32'h0BADF00D; man_err = 1'b1;
    @(posedge clk); #1; man_rdt = 32'hFFFFFFFF; man_err = 1'b0;
    repeat (3) @(posedge clk);

    // DLY=2 read, then reset one cycle later: the in-flight response must vanish.
    #1;
    sub_vld = 1'b1; sub_ben = 4'hF; sub_adr = 32'h44;
    @(posedge clk); #1; sub_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.rdt", rdt_o[2], 32'h0);
    chk("rst_mid.err", {31'd0, err_o[2]}, 32'h0);
    @(posedge clk); #1; man_rdt = 32'hCAFEBABE; man_err = 1'b1;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_after.rdt", rdt_o[2], 32'h0);
      chk("rst_after.err", {31'd0, err_o[2]}, 32'h0);
    end
    @(posedge clk); #1; man_rdt = 32'hFFFFFFFF; man_err = 1'b1;

    // DLY=0 with man_rdy low for 3 cycles: nothing accepted, nothing updated.
    sub_vld = 1'b1; sub_wen = 1'b0; sub_ben = 4'hF; sub_adr = 32'h80; man_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.rdy", {31'd0, rdy_o[3]}, 32'h0);
      chk("stall.vld", {31'd0, mvld_o[3]}, 32'h1);
      @(negedge clk);
      chk("stall.rdt", rdt_o[3], 32'h0);
      @(posedge clk); #1;
    end
    man_rdy = 1'b1; man_rdt = 32'h0000CAFE; man_err = 1'b0;
    #1;
    chk("accept.rdy", {31'd0, rdy_o[3]}, 32'h1);
    push(cyc + 1, 3, 32'h0000CAFE, 1'b0);
    @(posedge clk); #1;
    sub_vld = 1'b0; man_rdt = 32'hFFFFFFFF; man_err = 1'b1;
    push(cyc + 1, 3, 32'h0000CAFE, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expected responses never checked", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
